// File: rtl/lvds_pkg.sv
// Shared constants and state type for the LVDS receive path.
//
// The init sequencer and the word aligner both use these defaults, so that
// the training pattern and the bitslip latency are defined in one place.
// Contents:
//   align_state_t       - word aligner FSM states
//   LVDS_DATA_WIDTH     - deserialization factor
//   LVDS_TRAIN_PATTERN  - training word sent by the far end
//   LVDS_MATCH_COUNT    - consecutive good words that declare alignment
//   LVDS_SLIP_WAIT      - RX core bitslip latency, in clk cycles
package lvds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        WAIT,
        LOCKED,
        FAIL
    } align_state_t;

    localparam int         LVDS_DATA_WIDTH    = 10;
    localparam logic [9:0] LVDS_TRAIN_PATTERN = 10'h3E0;
    localparam int         LVDS_MATCH_COUNT   = 8;
    localparam int         LVDS_SLIP_WAIT     = 4;

endpackage

// File: rtl/lvds_word_aligner_if.sv
// Bundle between the LVDS RX core / init sequencer side and the word aligner.
//
// Signals:
//   start                  level, init sequence complete
//   rx_dpa_locked          DPA lock from the RX core
//   rx_data                deserialized word, one per clk
//   rx_channel_data_align  single-cycle bitslip pulse to the RX core
//   aligned                word boundary found
//   align_error            full rotation tried without finding the pattern
//   slip_count             bitslips issued in the current attempt
// Modports: master drives the inputs and observes the results; slave is
// the aligner.
interface lvds_word_aligner_if
    import lvds_pkg::*;
#(
    parameter int DATA_WIDTH = LVDS_DATA_WIDTH
);
    localparam int SLIP_W = $clog2(DATA_WIDTH + 1);

    logic                  start;
    logic                  rx_dpa_locked;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_channel_data_align;
    logic                  aligned;
    logic                  align_error;
    logic [SLIP_W-1:0]     slip_count;

    modport master (
        output start, rx_dpa_locked, rx_data,
        input  rx_channel_data_align, aligned, align_error, slip_count
    );

    modport slave (
        input  start, rx_dpa_locked, rx_data,
        output rx_channel_data_align, aligned, align_error, slip_count
    );
endinterface

// File: rtl/lvds_word_aligner.sv
// LVDS word aligner.
//
// After the init sequence completes and DPA is locked, the deserialized
// words are compared against TRAIN_PATTERN. On a mismatch, a single-cycle
// bitslip pulse is sent to the RX core, and comparisons are suspended for
// SLIP_WAIT cycles while the core applies the slip. MATCH_COUNT consecutive
// good words give LOCKED (aligned=1). A mismatch after DATA_WIDTH slips
// gives FAIL (align_error=1). Loss of DPA lock or of start returns to IDLE.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  synchronous reset, active HIGH (the name is historical)
//   bus    lvds_word_aligner_if slave
//          (start, rx_dpa_locked, rx_data in;
//           rx_channel_data_align, aligned, align_error, slip_count out)
// All outputs are registered.
module lvds_word_aligner
    import lvds_pkg::*;
#(
    parameter int                    DATA_WIDTH    = LVDS_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(LVDS_TRAIN_PATTERN),
    parameter int                    MATCH_COUNT   = LVDS_MATCH_COUNT,
    parameter int                    SLIP_WAIT     = LVDS_SLIP_WAIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lvds_word_aligner_if.slave   bus
);

    localparam int SLIP_W  = $clog2(DATA_WIDTH + 1);
    localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
    // Keep the wait counter at least one bit wide when SLIP_WAIT is 0.
    localparam int WAIT_W  = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    align_state_t       state_q, state_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0]  wait_next;
    logic [SLIP_W-1:0]  slip_count_q, slip_count_d;
    logic               align_pulse_q, align_pulse_d;
    logic               aligned_q, aligned_d;
    logic               align_error_q, align_error_d;
    logic               link_lost;

    // The slip counter stops at DATA_WIDTH, so it never wraps back to a
    // value that looks like a fresh attempt.
    function automatic logic [SLIP_W-1:0] slip_sat_inc(input logic [SLIP_W-1:0] v);
        if (v >= SLIP_W'(DATA_WIDTH)) begin
            return SLIP_W'(DATA_WIDTH);
        end
        return v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        slip_count_d = slip_count_q;
        wait_next    = wait_cnt_q + 1'b1;

        // Losing DPA lock or start has the same priority. Either one aborts
        // any activity, including a finished LOCKED or FAIL.
        link_lost = (state_q != IDLE) && (!bus.rx_dpa_locked || !bus.start);

        if (link_lost) begin
            state_d      = IDLE;
            match_cnt_d  = '0;
            wait_cnt_d   = '0;
            slip_count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && bus.rx_dpa_locked) begin
                        state_d      = CHECK;
                        match_cnt_d  = '0;
                        wait_cnt_d   = '0;
                        slip_count_d = '0;
                    end
                end
                CHECK: begin
                    if (bus.rx_data == TRAIN_PATTERN) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_q == MATCH_W'(MATCH_COUNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                        if (slip_count_q >= SLIP_W'(DATA_WIDTH)) begin
                            state_d = FAIL;
                        end else begin
                            state_d      = SLIP;
                            slip_count_d = slip_sat_inc(slip_count_q);
                        end
                    end
                end
                SLIP: begin
                    wait_cnt_d  = '0;
                    match_cnt_d = '0;
                    state_d     = (SLIP_WAIT == 0) ? CHECK : WAIT;
                end
                WAIT: begin
                    // rx_data is ignored here; the core is still applying the slip.
                    wait_cnt_d = wait_next;
                    if (wait_next == WAIT_W'(SLIP_WAIT)) begin
                        state_d     = CHECK;
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                end
                FAIL: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs follow the next state, so they line up with the state register.
        align_pulse_d = (state_d == SLIP);
        aligned_d     = (state_d == LOCKED);
        align_error_d = (state_d == FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= IDLE;
            match_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            slip_count_q  <= '0;
            align_pulse_q <= 1'b0;
            aligned_q     <= 1'b0;
            align_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            match_cnt_q   <= match_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            slip_count_q  <= slip_count_d;
            align_pulse_q <= align_pulse_d;
            aligned_q     <= aligned_d;
            align_error_q <= align_error_d;
        end
    end

    assign bus.rx_channel_data_align = align_pulse_q;
    assign bus.aligned               = aligned_q;
    assign bus.align_error           = align_error_q;
    assign bus.slip_count            = slip_count_q;

endmodule

// File: doc/lvds_word_aligner.md
Name: lvds_word_aligner

Overview:
Downstream of the LVDS receiver init sequencer. Once the init sequence completes and DPA is locked, it aligns deserialized word boundaries against a known training pattern. It issues single-cycle bitslip pulses (rx_channel_data_align) to the LVDS RX core until the pattern is seen for MATCH_COUNT consecutive words. It then reports aligned, or align_error if a full rotation fails.

Parameters:
DATA_WIDTH, 10, deserialization factor; width of rx_data.
TRAIN_PATTERN, 10'h3E0, expected training word; width DATA_WIDTH.
MATCH_COUNT, 8, consecutive matching words required to declare alignment; must be at least 1.
SLIP_WAIT, 4, cycles to wait after a bitslip pulse before comparing again (core bitslip latency).

Ports:
clk  in  1  single system clock; all logic on the rising edge.
rst_n  in  1  synchronous reset, active-HIGH (name kept per codebase); reset when 1.
start  in  1  level; init sequence complete; alignment begins while high.
rx_dpa_locked  in  1  DPA lock from the RX core.
rx_data  in  DATA_WIDTH  parallel word from the RX core, one word per clk.
rx_channel_data_align  out  1  bitslip pulse to the RX core; exactly 1 cycle wide.
aligned  out  1  high while in LOCKED.
align_error  out  1  high while in FAIL.
slip_count  out  $clog2(DATA_WIDTH+1)  number of bitslips issued in the current attempt.

Behaviour:
- All outputs are registered. Reset (rst_n=1 at a clk edge) forces:
  - state=IDLE, all outputs 0, internal match_cnt=0, wait_cnt=0.
  - This takes effect from the next cycle and applies in every state, including mid-SLIP and mid-WAIT.
- States: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL (enum align_state_t).
- IDLE:
  - When start=1 and rx_dpa_locked=1 → CHECK.
  - On entry, clear slip_count, match_cnt and wait_cnt.
- CHECK: compare rx_data with TRAIN_PATTERN every cycle.
  - On a match: match_cnt+1. When the match makes match_cnt reach MATCH_COUNT → LOCKED.
  - On a mismatch: match_cnt=0. If slip_count==DATA_WIDTH → FAIL, else → SLIP.
- SLIP:
  - Lasts one cycle: rx_channel_data_align=1 and slip_count+1. Then → WAIT with wait_cnt=0.
- WAIT:
  - rx_data is ignored. After SLIP_WAIT cycles → CHECK with match_cnt=0.
  - With SLIP_WAIT=0, go directly to CHECK.
- LOCKED:
  - aligned=1. slip_count is held at its final value. Mismatches are ignored.
- FAIL:
  - align_error=1. Stays in FAIL until start=0, then → IDLE. A retry requires start to be reasserted.
- Loss of lock:
  - rx_dpa_locked=0 in any state other than IDLE → IDLE next cycle.
  - aligned, align_error and the pulse are cleared. slip_count is cleared on the next IDLE entry.
- Loss of start:
  - start=0 in CHECK, SLIP, WAIT or LOCKED → IDLE. This has the same priority as DPA loss.
- Priority: reset > DPA loss > start loss > normal transitions.
- Latency: start and lock sampled at edge N → CHECK at N+1. For a perfectly aligned stream, aligned rises at edge N+1+MATCH_COUNT.
- Width rules: slip_count saturates at DATA_WIDTH and never wraps. match_cnt is sized $clog2(MATCH_COUNT+1) and wait_cnt is sized $clog2(SLIP_WAIT+1).
- The pulse is never asserted on two consecutive cycles. At most DATA_WIDTH pulses are issued per attempt.

Decomposition:
- Package lvds_pkg: align_state_t, plus the defaults for TRAIN_PATTERN and SLIP_WAIT, shared with the init sequencer's package constants.
- Single module. A sub-module is not warranted; the match and wait counters are inline.

Test Plan:
- Aligned stream: rx_data=10'h3E0 constantly, start=1, lock=1 at edge 0 → aligned=1 at edge 9, no align pulses, slip_count=0.
- Rotated by 3: bench model rotates rx_data by one bit SLIP_WAIT cycles after each pulse → exactly 3 one-cycle pulses, spaced 1+4+1 cycles apart, then aligned=1 with slip_count=3.
- Garbage data (10'h155 constant) → 10 pulses, then align_error=1, slip_count=10. Deassert start → IDLE and error clears. Reassert start → slip_count restarts from 0.
- Partial match: 5 good words, then 1 bad word → pulse issued and match_cnt cleared; after WAIT, 8 good words → aligned.
- DPA loss mid-WAIT and in LOCKED: rx_dpa_locked=0 → next cycle aligned=0 and state IDLE. Relock with start=1 → alignment restarts with slip_count=0.
- Reset asserted during the SLIP cycle → next cycle all outputs 0 and state IDLE. No second pulse occurs after reset releases until a new mismatch.
